// File: rtl/i2c_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one I2C master slave port between NUM_REQ requesters.
// Grant is locked for the owner's whole cyc period; a watchdog errors out unacknowledged strobes.
module i2c_wb_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      m_cyc_i,
    input  logic [NUM_REQ-1:0]      m_stb_i,
    input  logic [NUM_REQ-1:0]      m_we_i,
    input  logic [32*NUM_REQ-1:0]   m_addr_i,
    input  logic [32*NUM_REQ-1:0]   m_data_i,
    output logic [31:0]             m_data_o,
    output logic [NUM_REQ-1:0]      m_ack_o,
    output logic [NUM_REQ-1:0]      m_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [31:0]             s_addr_o,
    output logic [31:0]             s_data_o,
    input  logic [31:0]             s_data_i,
    input  logic                    s_ack_i,
    output logic [NUM_REQ-1:0]      grant_o
);

    localparam int unsigned OwnW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit WdogEn = (TIMEOUT_CYCLES > 0);

    typedef enum logic {StIdle, StOwned} state_e;

    state_e          state_q, state_d;
    logic [OwnW-1:0] owner_q, owner_d;
    logic [OwnW-1:0] last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            pick_found;
    logic [OwnW-1:0] pick_idx;
    logic [OwnW-1:0] cand;

    logic            owned;
    logic            own_cyc;
    logic            own_stb;
    logic            stall;
    logic            expire;

    // Circular search starting just after the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = OwnW'((int'(last_q) + i) % int'(NUM_REQ));
            if (!pick_found && m_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owned   = (state_q == StOwned);
    assign own_cyc = m_cyc_i[owner_q];
    assign own_stb = m_stb_i[owner_q];
    assign stall   = owned && own_cyc && own_stb && !s_ack_i;
    assign expire  = WdogEn && stall && (cnt_q == CntLast);

    always_comb begin
        grant_o  = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        m_data_o = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        if (owned) begin
            grant_o[owner_q] = 1'b1;
            m_ack_o[owner_q] = s_ack_i;
            m_err_o[owner_q] = expire;
            m_data_o         = s_data_i;
            s_cyc_o          = own_cyc;
            s_stb_o          = own_cyc && own_stb && !expire;
            s_we_o           = m_we_i[owner_q];
            s_addr_o         = m_addr_i[32*owner_q +: 32];
            s_data_o         = m_data_i[32*owner_q +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pick_found) begin
                    state_d = StOwned;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                end
            end
            StOwned: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (WdogEn && stall && !expire) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= OwnW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Scoreboard bench for i2c_wb_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural ownership model.
module tb_i2c_wb_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  m_cyc, m_stb, m_we;
    logic [63:0]   m_addr, m_wdata;
    logic [31:0]   m_rdata;
    logic [N-1:0]  m_ack, m_err, grant;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [31:0]   s_addr, s_wdata, s_rdata;

    always #5 clk = ~clk;

    i2c_wb_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_addr_i (m_addr),
        .m_data_i (m_wdata),
        .m_data_o (m_rdata),
        .m_ack_o  (m_ack),
        .m_err_o  (m_err),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_addr_o (s_addr),
        .s_data_o (s_wdata),
        .s_data_i (s_rdata),
        .s_ack_i  (s_ack),
        .grant_o  (grant)
    );

    typedef struct {
        logic [N-1:0] grant, ack, err;
        logic         scyc, sstb, swe;
        logic [31:0]  saddr, sdata, mdata;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: owner index (-1 = idle), previous owner, consecutive stalled cycles.
    int own = -1;
    int last = N - 1;
    int stall = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic drive(input logic [N-1:0] c, input logic [N-1:0] s, input logic [N-1:0] w,
                         input logic a, input logic r);
        exp_t e;
        bit   oc, sb, stl, ex;
        m_cyc = c;
        m_stb = s;
        m_we  = w;
        s_ack = a;
        rst_n = r;
        e = '{default: '0};
        oc = 0; sb = 0; stl = 0; ex = 0;
        if (own >= 0) begin
            oc  = m_cyc[own];
            sb  = oc && m_stb[own];
            stl = sb && !s_ack;
            ex  = stl && (stall == TO - 1);
            e.grant      = N'(1 << own);
            e.scyc       = oc;
            e.sstb       = sb && !ex;
            e.swe        = m_we[own];
            e.saddr      = m_addr[32*own +: 32];
            e.sdata      = m_wdata[32*own +: 32];
            e.mdata      = s_rdata;
            e.ack[own]   = s_ack;
            e.err[own]   = ex;
        end
        q.push_back(e);
        if (!r) begin
            own = -1; last = N - 1; stall = 0;
        end else if (own < 0) begin
            stall = 0;
            for (int k = 1; k <= N; k++) begin
                if (m_cyc[(last + k) % N]) begin
                    own  = (last + k) % N;
                    last = own;
                    break;
                end
            end
        end else if (!oc) begin
            own = -1; stall = 0;
        end else if (stl && !ex) begin
            stall++;
        end else begin
            stall = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [N-1:0] c, input logic [N-1:0] s, input logic [N-1:0] w,
                        input logic a, input logic r);
        m_addr  = {$urandom, $urandom};
        m_wdata = {$urandom, $urandom};
        s_rdata = $urandom;
        drive(c, s, w, a, r);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", 32'(grant), 32'(e.grant));
                chk("m_ack", 32'(m_ack), 32'(e.ack));
                chk("m_err", 32'(m_err), 32'(e.err));
                chk("s_cyc", 32'(s_cyc), 32'(e.scyc));
                chk("s_stb", 32'(s_stb), 32'(e.sstb));
                chk("s_we", 32'(s_we), 32'(e.swe));
                chk("s_addr", s_addr, e.saddr);
                chk("s_data", s_wdata, e.sdata);
                chk("m_data", m_rdata, e.mdata);
            end
        end
    end

    initial begin : stim
        logic [N-1:0] c, s, w;
        rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
        m_addr = '0; m_wdata = '0; s_rdata = '0;
        @(posedge clk);
        #1;
        step(2'b00, 2'b00, 2'b00, 0, 0);
        step(2'b00, 2'b00, 2'b00, 0, 1);

        // Single write by requester 1: addr 0x04, data 0xA5.
        m_addr  = {32'h0000_0004, 32'h0};
        m_wdata = {32'h0000_00A5, 32'h0};
        s_rdata = 32'h1234_5678;
        drive(2'b10, 2'b10, 2'b10, 0, 1);
        drive(2'b10, 2'b10, 2'b10, 0, 1);
        drive(2'b10, 2'b10, 2'b10, 1, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);

        // Simultaneous request; requester 0 keeps cyc across three accesses and a stb gap.
        step(2'b11, 2'b11, 2'b00, 0, 1);
        step(2'b11, 2'b11, 2'b01, 1, 1);
        step(2'b11, 2'b10, 2'b00, 0, 1);
        step(2'b11, 2'b11, 2'b01, 1, 1);
        step(2'b11, 2'b11, 2'b00, 1, 1);
        step(2'b10, 2'b10, 2'b00, 0, 1);
        step(2'b10, 2'b10, 2'b00, 0, 1);
        step(2'b10, 2'b10, 2'b00, 1, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);

        // Both requesters keep asking; each owner does one access then releases.
        repeat (4) begin
            step(2'b11, 2'b11, 2'b00, 0, 1);
            step(2'b11, 2'b11, 2'b00, 1, 1);
            c = 2'b11 & ~N'(1 << own);
            step(c, c, 2'b00, 0, 1);
        end
        step(2'b00, 2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);

        // Slave never acks: watchdog fires twice while ownership is kept.
        step(2'b01, 2'b01, 2'b00, 0, 1);
        repeat (18) step(2'b01, 2'b01, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);

        // Ack lands on the cycle the watchdog would expire.
        step(2'b10, 2'b10, 2'b00, 0, 1);
        repeat (7) step(2'b10, 2'b10, 2'b00, 0, 1);
        step(2'b10, 2'b10, 2'b00, 1, 1);
        step(2'b10, 2'b10, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);

        // Reset during requester 1's ownership, then both request.
        step(2'b10, 2'b10, 2'b10, 0, 1);
        step(2'b10, 2'b10, 2'b10, 0, 1);
        step(2'b10, 2'b10, 2'b10, 0, 0);
        step(2'b11, 2'b11, 2'b00, 0, 1);
        step(2'b11, 2'b11, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 2'b00, 0, 1);

        // Random traffic.
        c = '0;
        repeat (600) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) c[i] = ~c[i];
            end
            s = N'($urandom);
            w = N'($urandom);
            step(c, s, w, $urandom_range(2) == 0, $urandom_range(149) != 0);
        end

        repeat (2) @(posedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_wb_arbiter.md
# i2c_wb_arbiter

Round-robin Wishbone arbiter that shares the single I2C master peripheral between NUM_REQ bus requesters, e.g. the CPU data port and a boot-time sensor-init engine. It sits between the requesters and the I2C master's Wishbone slave port. A grant is locked for the whole `cyc` period, so a multi-access I2C sequence (address, data, start, status polling) is never interleaved with another requester's accesses. A watchdog returns an error to the owner if the I2C master fails to acknowledge.

## Interface

Parameters:

- NUM_REQ, 2: number of requesters, 2..4.
- TIMEOUT_CYCLES, 1024: cycles without ack before a watchdog error; 0 disables the watchdog.

Ports:

- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- m_cyc_i  in  NUM_REQ  per-requester cycle; bit i belongs to requester i.
- m_stb_i  in  NUM_REQ  per-requester strobe.
- m_we_i  in  NUM_REQ  per-requester write enable.
- m_addr_i  in  32*NUM_REQ  requester i uses slice [32i+31:32i].
- m_data_i  in  32*NUM_REQ  write data, sliced as for m_addr_i.
- m_data_o  out  32  read data, s_data_i broadcast to all requesters.
- m_ack_o  out  NUM_REQ  ack, only to the owner.
- m_err_o  out  NUM_REQ  watchdog error pulse, only to the owner.
- s_cyc_o  out  1  cycle to the I2C master.
- s_stb_o  out  1  strobe to the I2C master.
- s_we_o  out  1  write enable to the I2C master.
- s_addr_o  out  32  address to the I2C master.
- s_data_o  out  32  write data to the I2C master.
- s_data_i  in  32  read data from the I2C master.
- s_ack_i  in  1  ack from the I2C master.
- grant_o  out  NUM_REQ  one-hot owner; all zero when idle.

## Operation

- States: IDLE and OWNED. The owner index is registered.
- In IDLE, when any m_cyc_i bit is high:
  - pick the first requester with cyc high, searching circularly from last_owner+1;
  - register it as owner, set last_owner to it, and go to OWNED at the next edge.
- In OWNED:
  - the owner's cyc/stb/we/addr/data are muxed combinationally to the s_* outputs;
  - s_ack_i is routed combinationally to m_ack_o[owner];
  - non-owners see ack=0 and err=0, and their stb is ignored (they wait).
- Lock: ownership persists while m_cyc_i[owner] is high, including across stb-low gaps.
- Release: when m_cyc_i[owner] is low in OWNED, s_cyc_o and s_stb_o drop the same cycle and the state returns to IDLE at the next edge.
- The IDLE outputs are s_cyc_o=s_stb_o=s_we_o=0; s_addr_o and s_data_o are zero.
- Watchdog:
  - counter width is $clog2(TIMEOUT_CYCLES+1);
  - it increments each OWNED cycle with s_stb_o=1 and s_ack_i=0, and clears on ack, on stb low, or on leaving OWNED;
  - when the count equals TIMEOUT_CYCLES-1 while the stall condition holds, that cycle pulses m_err_o[owner]=1 and forces s_stb_o=0, and the counter clears;
  - ownership is kept; the requester decides whether to drop cyc.
- An ack and a timeout in the same cycle resolve as ack: no error.
- Fairness: with all requesters holding cyc continuously, each gets one ownership per rotation. The rotation order is i, i+1, …, wrapping at NUM_REQ-1 back to 0.

## Timing

- Reset sets: state=IDLE, owner none, grant_o=0, last_owner=NUM_REQ-1 (requester 0 wins first), counter=0. All outputs are 0.
- Grant latency: a requester raising cyc in cycle t, while IDLE, sees grant_o and s_cyc_o high in cycle t+1.
- The data path has no added latency: s_ack_i to m_ack_o and s_data_i to m_data_o are combinational.
- Handover: owner drops cyc in cycle t → IDLE in t+1, where arbitration happens → the new owner drives s_cyc_o in t+2.
- A reset asserted mid-transfer returns to IDLE at that edge and drops s_cyc_o the next cycle. The I2C master is reset by the same rst_n.

## Test plan

- After reset, only requester 1 raises cyc+stb, writing addr 0x04 and data 0xA5. Required: s_cyc_o=1 and grant_o=2'b10 exactly one cycle later, s_data_o=0xA5, and m_ack_o[1] in the same cycle as s_ack_i.
- Both requesters raise cyc in the same cycle after reset. Required: requester 0 is granted first. Requester 0 performs 3 accesses without dropping cyc, and requester 1 gets no ack during them. Requester 1 is granted 2 cycles after requester 0 drops cyc.
- Both requesters hold cyc continuously across 4 ownerships. Required: grant sequence 0,1,0,1.
- TIMEOUT_CYCLES=8 and the slave never acks. Required: m_err_o[owner] pulses for exactly one cycle in the 8th stalled cycle, s_stb_o=0 in that cycle, and the owner is unchanged.
- s_ack_i is asserted in the same cycle the watchdog would expire. Required: m_ack_o=1 and m_err_o=0.
- rst_n is pulled low during requester 1's ownership. Required: all outputs 0 the next cycle and grant_o=0; after reset releases with both requesting, requester 0 wins.
